// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: REG0/REG1 (RW), SUM = REG0+REG1 (RO), WCOUNT (RO).
// Define AXIL_REG_WCOUNT_EN to build the write counter behind offset 0xC.
module axil_reg_slave #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter int unsigned           RESP_WIDTH = 3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [DATA_WIDTH-1:0] REG0_RESET = '0,
    parameter logic [DATA_WIDTH-1:0] REG1_RESET = '0
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [RESP_WIDTH-1:0]   s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = '0;
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        return (a[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]) && (a[1:0] == 2'b00);
    endfunction

    // Top strobe bit carries no byte lane.
    logic unused_wstrb_msb;
    assign unused_wstrb_msb = s0_axi_wstrb[STRB_W];

    // ---------------- register file ----------------
    logic [DATA_WIDTH-1:0] reg0_q, reg0_d;
    logic [DATA_WIDTH-1:0] reg1_q, reg1_d;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] rd_wcount;

    assign sum = reg0_q + reg1_q;

    // ---------------- write channel ----------------
    wstate_t               wstate_q, wstate_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic                  awready_q, awready_d;
    logic                  wready_q, wready_d;
    logic                  bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0] bresp_q, bresp_d;

    logic                  aw_fire, w_fire, b_fire;
    logic                  commit, cmt_ok;
    logic [ADDR_WIDTH-1:0] cmt_addr;
    logic [DATA_WIDTH-1:0] cmt_data;
    logic [STRB_W-1:0]     cmt_strb;

    assign aw_fire = s0_axi_awvalid && awready_q;
    assign w_fire  = s0_axi_wvalid  && wready_q;
    assign b_fire  = bvalid_q && s0_axi_bready;

    // Commit data comes from whichever half arrived earlier (latched) and the half arriving now.
    always_comb begin
        wstate_d = wstate_q;
        awaddr_d = awaddr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        commit   = 1'b0;
        cmt_addr = awaddr_q;
        cmt_data = wdata_q;
        cmt_strb = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_fire && w_fire) begin
                    cmt_addr = s0_axi_awaddr;
                    cmt_data = s0_axi_wdata;
                    cmt_strb = s0_axi_wstrb[STRB_W-1:0];
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end else if (aw_fire) begin
                    awaddr_d = s0_axi_awaddr;
                    wstate_d = W_ADDR;
                end else if (w_fire) begin
                    wdata_d  = s0_axi_wdata;
                    wstrb_d  = s0_axi_wstrb[STRB_W-1:0];
                    wstate_d = W_DATA;
                end
            end
            W_ADDR: begin
                if (w_fire) begin
                    cmt_data = s0_axi_wdata;
                    cmt_strb = s0_axi_wstrb[STRB_W-1:0];
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_DATA: begin
                if (aw_fire) begin
                    cmt_addr = s0_axi_awaddr;
                    commit   = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_fire) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase

        cmt_ok  = addr_hit(cmt_addr) && (cmt_addr[3] == 1'b0);
        bresp_d = bresp_q;
        if (commit) begin
            bresp_d = cmt_ok ? RESP_OKAY : RESP_SLVERR;
        end

        awready_d = (wstate_d == W_IDLE) || (wstate_d == W_DATA);
        wready_d  = (wstate_d == W_IDLE) || (wstate_d == W_ADDR);
        bvalid_d  = (wstate_d == W_RESP);
    end

    always_comb begin
        reg0_d = reg0_q;
        reg1_d = reg1_q;
        if (commit && cmt_ok) begin
            for (int unsigned i = 0; i < STRB_W; i++) begin
                if (cmt_strb[i]) begin
                    if (cmt_addr[2]) begin
                        reg1_d[8*i +: 8] = cmt_data[8*i +: 8];
                    end else begin
                        reg0_d[8*i +: 8] = cmt_data[8*i +: 8];
                    end
                end
            end
        end
    end

`ifdef AXIL_REG_WCOUNT_EN
    logic [DATA_WIDTH-1:0] wcount_q, wcount_d;

    always_comb begin
        wcount_d = wcount_q;
        if (commit && cmt_ok) begin
            wcount_d = wcount_q + DATA_WIDTH'(1);
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            wcount_q <= '0;
        end else begin
            wcount_q <= wcount_d;
        end
    end

    assign rd_wcount = wcount_q;
`else
    assign rd_wcount = '0;
`endif

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            wstate_q  <= W_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            reg0_q    <= REG0_RESET;
            reg1_q    <= REG1_RESET;
        end else begin
            wstate_q  <= wstate_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            reg0_q    <= reg0_d;
            reg1_q    <= reg1_d;
        end
    end

    // ---------------- read channel ----------------
    rstate_t               rstate_q, rstate_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0] rresp_q, rresp_d;
    logic                  ar_fire, r_fire;
    logic                  rd_hit;
    logic [DATA_WIDTH-1:0] rd_val;

    assign ar_fire = s0_axi_arvalid && arready_q;
    assign r_fire  = rvalid_q && s0_axi_rready;
    assign rd_hit  = addr_hit(s0_axi_araddr);

    // Sampled from the _q registers, so a same-edge write commit is not yet visible.
    always_comb begin
        case (s0_axi_araddr[3:2])
            2'd0:    rd_val = reg0_q;
            2'd1:    rd_val = reg1_q;
            2'd2:    rd_val = sum;
            default: rd_val = rd_wcount;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rdata_d  = rd_hit ? rd_val : '0;
                    rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_fire) begin
                    rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        arready_d = (rstate_d == R_IDLE);
        rvalid_d  = (rstate_d == R_DATA);
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (s0_axi_areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign s0_axi_awready = awready_q;
    assign s0_axi_wready  = wready_q;
    assign s0_axi_bvalid  = bvalid_q;
    assign s0_axi_bresp   = bresp_q;
    assign s0_axi_arready = arready_q;
    assign s0_axi_rvalid  = rvalid_q;
    assign s0_axi_rdata   = rdata_q;
    assign s0_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Bench for axil_reg_slave: directed transactions checked against a register-map model.
module tb_axil_reg_slave;

    localparam logic [31:0] R0_RST = 32'h1234_5678;
    localparam logic [31:0] R1_RST = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        areset;
    logic [7:0]  awaddr, araddr;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [4:0]  wstrb;
    logic [2:0]  bresp, rresp;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axil_reg_slave #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8),
        .RESP_WIDTH(3),
        .BASE_ADDR (8'h00),
        .REG0_RESET(R0_RST),
        .REG1_RESET(R1_RST)
    ) dut (
        .s0_axi_aclk   (clk),
        .s0_axi_areset (areset),
        .s0_axi_awaddr (awaddr),
        .s0_axi_awvalid(awvalid),
        .s0_axi_awready(awready),
        .s0_axi_wdata  (wdata),
        .s0_axi_wstrb  (wstrb),
        .s0_axi_wvalid (wvalid),
        .s0_axi_wready (wready),
        .s0_axi_bresp  (bresp),
        .s0_axi_bvalid (bvalid),
        .s0_axi_bready (bready),
        .s0_axi_araddr (araddr),
        .s0_axi_arvalid(arvalid),
        .s0_axi_arready(arready),
        .s0_axi_rdata  (rdata),
        .s0_axi_rresp  (rresp),
        .s0_axi_rvalid (rvalid),
        .s0_axi_rready (rready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- register-map model ----------------
    logic [31:0] m_reg0, m_reg1, m_wcount;
    logic [2:0]  bq[$];
    logic [34:0] rq[$];

    function automatic bit m_hit(input logic [7:0] a);
        return (a[7:4] == 4'h0) && (a[1:0] == 2'b00);
    endfunction

    task automatic m_reset();
        m_reg0 = R0_RST;
        m_reg1 = R1_RST;
        m_wcount = 32'd0;
        bq.delete();
        rq.delete();
    endtask

    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] v;
        if (m_hit(a) && a[3] == 1'b0) begin
            v = a[2] ? m_reg1 : m_reg0;
            for (int i = 0; i < 4; i++)
                if (s[i]) v[8*i +: 8] = d[8*i +: 8];
            if (a[2]) m_reg1 = v; else m_reg0 = v;
            m_wcount = m_wcount + 32'd1;
            bq.push_back(3'd0);
        end else begin
            bq.push_back(3'd2);
        end
    endtask

    task automatic m_read(input logic [7:0] a);
        logic [31:0] v;
        if (!m_hit(a)) begin
            rq.push_back({3'd2, 32'd0});
        end else begin
            case (a[3:2])
                2'd0: v = m_reg0;
                2'd1: v = m_reg1;
                2'd2: v = m_reg0 + m_reg1;
`ifdef AXIL_REG_WCOUNT_EN
                default: v = m_wcount;
`else
                default: v = 32'd0;
`endif
            endcase
            rq.push_back({3'd0, v});
        end
    endtask

    // ---------------- compare process ----------------
    logic        pb_hold = 1'b0, pr_hold = 1'b0;
    logic [2:0]  pb_resp, pr_resp;
    logic [31:0] pr_data;

    always @(negedge clk) begin
        if (areset) begin
            pb_hold = 1'b0;
            pr_hold = 1'b0;
        end else begin
            if (pb_hold) chk("b_hold", 64'({bvalid, bresp}), 64'({1'b1, pb_resp}));
            if (pr_hold) chk("r_hold", 64'({rvalid, rresp, rdata}), 64'({1'b1, pr_resp, pr_data}));
            if (bvalid) begin
                if (bq.size() == 0) chk("b_unexpected", 64'(bvalid), 64'd0);
                else begin
                    chk("bresp", 64'(bresp), 64'(bq[0]));
                    if (bready) void'(bq.pop_front());
                end
            end
            if (rvalid) begin
                if (rq.size() == 0) chk("r_unexpected", 64'(rvalid), 64'd0);
                else begin
                    chk("rresp_rdata", 64'({rresp, rdata}), 64'(rq[0]));
                    if (rready) void'(rq.pop_front());
                end
            end
            pb_hold = bvalid && !bready;
            pb_resp = bresp;
            pr_hold = rvalid && !rready;
            pr_resp = rresp;
            pr_data = rdata;
        end
    end

    // ---------------- drivers ----------------
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                      input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done, w_done, aw_f, w_f, b_f;
        int cyc;
        m_write(a, d, s);
        aw_done = 0; w_done = 0; cyc = 0;
        awaddr = a; wdata = d; wstrb = {1'b1, s};
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            @(negedge clk);
            if (w_done && !aw_done) chk("w_data_ready", 64'({awready, wready}), 64'd2);
            if (aw_done && !w_done) chk("w_addr_ready", 64'({awready, wready}), 64'd1);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk); #1;
            aw_done = aw_done | aw_f;
            w_done  = w_done | w_f;
            cyc++;
            if (cyc > 50) begin
                chk("aw_w_timeout", 64'({aw_done, w_done}), 64'd3);
                break;
            end
        end
        awvalid = 0; wvalid = 0; cyc = 0;
        while (1) begin
            bready = (cyc >= b_dly);
            @(negedge clk);
            b_f = bvalid && bready;
            @(posedge clk); #1;
            if (b_f) break;
            cyc++;
            if (cyc > 50) begin
                chk("b_timeout", 64'(bvalid), 64'd1);
                break;
            end
        end
        bready = 0;
    endtask

    task automatic rd(input logic [7:0] a, input int r_dly, input bit push,
                      output logic [31:0] data, output logic [2:0] resp);
        bit f;
        int cyc;
        if (push) m_read(a);
        data = '0; resp = '0;
        araddr = a; arvalid = 1; cyc = 0;
        while (1) begin
            @(negedge clk);
            f = arvalid && arready;
            @(posedge clk); #1;
            if (f) break;
            cyc++;
            if (cyc > 50) begin
                chk("ar_timeout", 64'(arready), 64'd1);
                break;
            end
        end
        arvalid = 0; cyc = 0;
        while (1) begin
            rready = (cyc >= r_dly);
            @(negedge clk);
            f = rvalid && rready;
            data = rdata; resp = rresp;
            @(posedge clk); #1;
            if (f) break;
            cyc++;
            if (cyc > 50) begin
                chk("r_timeout", 64'(rvalid), 64'd1);
                break;
            end
        end
        rready = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected below 500000", $time);
        $fatal(1);
    end

    logic [31:0] d;
    logic [2:0]  r;
    logic [31:0] exp_cnt;

    initial begin
        areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; araddr = 0; wdata = 0; wstrb = 0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset_handshake", 64'({awready, wready, arready, bvalid, rvalid}), 64'd0);
        chk("reset_data", 64'({bresp, rresp, rdata}), 64'd0);
        @(posedge clk); #1;
        areset = 0;
        @(negedge clk);
        chk("ready_before_edge", 64'({awready, wready, arready}), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_release", 64'({awready, wready, arready}), 64'd7);
        @(posedge clk); #1;

        rd(8'h00, 0, 1, d, r);
        chk("reg0_reset_lit", 64'({r, d}), 64'({3'd0, 32'h1234_5678}));
        rd(8'h04, 1, 1, d, r);

        // SUM wrap
        wr(8'h00, 32'h0000_00FF, 4'hF, 0, 0, 0);
        wr(8'h04, 32'hFFFF_FF02, 4'hF, 0, 0, 0);
        rd(8'h08, 0, 1, d, r);
        chk("sum_wrap_lit", 64'({r, d}), 64'({3'd0, 32'h0000_0001}));
        rd(8'h0C, 0, 1, d, r);
`ifdef AXIL_REG_WCOUNT_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        chk("wcount_lit", 64'(d), 64'(exp_cnt));

        // Byte strobes
        wr(8'h00, 32'h1122_3344, 4'hF, 0, 0, 0);
        wr(8'h00, 32'hAABB_CCDD, 4'b0101, 0, 0, 1);
        rd(8'h00, 0, 1, d, r);
        chk("strobe_merge_lit", 64'(d), 64'h11BB_33DD);

        // W three cycles ahead of AW, B held off for four cycles
        wr(8'h04, 32'hCAFE_F00D, 4'hF, 3, 0, 4);
        rd(8'h04, 0, 1, d, r);
        chk("late_aw_lit", 64'(d), 64'hCAFE_F00D);
        rd(8'h0C, 2, 1, d, r);
        // AW ahead of W
        wr(8'h04, 32'h0BAD_0001, 4'b0011, 0, 2, 0);
        rd(8'h04, 0, 1, d, r);
        chk("late_w_lit", 64'(d), 64'hCAFE_0001);

        // Error paths
        wr(8'h08, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        wr(8'h0C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        wr(8'h10, 32'hFFFF_FFFF, 4'hF, 1, 0, 0);
        wr(8'h01, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        rd(8'h10, 0, 1, d, r);
        chk("miss_read_lit", 64'({r, d}), 64'({3'd2, 32'd0}));
        rd(8'h06, 0, 1, d, r);
        rd(8'h00, 0, 1, d, r);
        rd(8'h04, 0, 1, d, r);
        rd(8'h0C, 0, 1, d, r);

        // Same-edge commit and AR: read sees the pre-write value
        m_read(8'h00);
        fork
            wr(8'h00, 32'h5555_AAAA, 4'hF, 0, 0, 0);
            rd(8'h00, 0, 0, d, r);
        join
        chk("same_edge_lit", 64'(d), 64'h11BB_33DD);
        rd(8'h00, 0, 1, d, r);
        rd(8'h08, 0, 1, d, r);

        // Back-to-back writes and reads
        for (int i = 0; i < 4; i++) begin
            wr(8'(4 * (i % 2)), 32'h0101_0101 * 32'(i + 1), 4'hF, 0, 0, 0);
        end
        for (int i = 0; i < 4; i++) begin
            rd(8'(4 * i), 0, 1, d, r);
        end

        // Reset while the B response is pending
        awaddr = 8'h00; wdata = 32'hDEAD_BEEF; wstrb = 5'h0F; awvalid = 1; wvalid = 1; bready = 0;
        bq.push_back(3'd0);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        @(negedge clk);
        chk("b_pending", 64'(bvalid), 64'd1);
        areset = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_dropped", 64'({bvalid, awready}), 64'd0);
        areset = 0;
        m_reset();
        @(posedge clk); #1;
        rd(8'h00, 0, 1, d, r);
        chk("reg0_after_reset_lit", 64'(d), 64'h1234_5678);
        rd(8'h04, 0, 1, d, r);
        rd(8'h0C, 0, 1, d, r);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("bq_drained", 64'(bq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axil_reg_slave.md
# axil_reg_slave

AXI4-Lite register slave that terminates one master port of the `bus` interconnect (connects to its `m1_*` or `m2_*` side). It exposes two read/write data registers, a read-only wrapping sum of those two registers, and an optional write counter. It is the endpoint that the interconnect's address decode forwards writes and reads to.

## Interface
- `DATA_WIDTH`, 32, register and data bus width.
- `ADDR_WIDTH`, 8, address width.
- `RESP_WIDTH`, 3, response field width. It matches the interconnect; only codes 0 (OKAY) and 2 (SLVERR) are produced.
- `BASE_ADDR`, 0, block base. Only bits `[ADDR_WIDTH-1:4]` are compared.
- `REG0_RESET`, 0, reset value of REG0.
- `REG1_RESET`, 0, reset value of REG1.

Ports:
- `s0_axi_aclk`  in  1  the single clock. All logic is on the rising edge.
- `s0_axi_areset`  in  1  synchronous, active-high reset.
- `s0_axi_awaddr`  in  ADDR_WIDTH;  `s0_axi_awvalid` in 1;  `s0_axi_awready` out 1.
- `s0_axi_wdata`  in  DATA_WIDTH;  `s0_axi_wstrb` in DATA_WIDTH/8+1 (MSB ignored);  `s0_axi_wvalid` in 1;  `s0_axi_wready` out 1.
- `s0_axi_bresp`  out  RESP_WIDTH;  `s0_axi_bvalid` out 1;  `s0_axi_bready` in 1.
- `s0_axi_araddr`  in  ADDR_WIDTH;  `s0_axi_arvalid` in 1;  `s0_axi_arready` out 1.
- `s0_axi_rdata`  out  DATA_WIDTH;  `s0_axi_rresp` out RESP_WIDTH;  `s0_axi_rvalid` out 1;  `s0_axi_rready` in 1.

## Operation
- **Address decode.**
  - An address is a hit when `addr[ADDR_WIDTH-1:4]==BASE_ADDR[ADDR_WIDTH-1:4]` and `addr[1:0]==0`.
  - Offsets: 0x0 REG0 (RW), 0x4 REG1 (RW), 0x8 SUM (RO), 0xC WCOUNT (RO).
  - A miss is any address that fails the hit test.
- **SUM.** `(REG0+REG1) mod 2^DATA_WIDTH`, taken from current register values. There is no carry out.
- **Write FSM.**
  - States and transitions:
    - W_IDLE: AW accepted only → W_ADDR; W accepted only → W_DATA; both accepted in the same cycle → W_RESP.
    - W_ADDR (`awready=0`, `wready=1`): on W accepted → W_RESP.
    - W_DATA (`awready=1`, `wready=0`): on AW accepted → W_RESP.
    - W_RESP: `bvalid=1` and held until `bready` → W_IDLE.
  - In W_IDLE, `awready=1` and `wready=1`.
  - The commit happens on the edge entering W_RESP. Each strobe bit `i` enables byte `i` of a hit RW register.
  - Write to REG0/REG1 → `bresp=0`.
  - Write to offset 0x8/0xC, or a miss → `bresp=2`, and no register changes.
- **Read FSM.**
  - R_IDLE (`arready=1`): on AR accepted, `rdata`/`rresp` are registered → R_DATA.
  - R_DATA: `arready=0`, `rvalid=1`, `rdata`/`rresp` stable until `rready` → R_IDLE.
  - A read hit on any offset → `rresp=0`. A miss → `rdata=0`, `rresp=2`.
- The read and write FSMs are independent and can run concurrently.

## Timing
- **Reset.** While `s0_axi_areset=1` at an edge:
  - All ready/valid outputs are 0, and `bresp`/`rresp`/`rdata` are 0.
  - REG0/REG1 take their `*_RESET` values and WCOUNT is 0.
  - Both FSMs return to idle.
  - `awready`, `wready` and `arready` are 1 from the first edge after reset is released.
- **Reset mid-transaction.** Any pending AW/W/AR or unacknowledged B/R is dropped with no commit and no response.
- **Write latency.** With AW and W in the same cycle, `bvalid` rises 1 cycle after the handshake, and the register value is visible from that edge.
- **Read latency.** `rvalid` rises 1 cycle after the AR handshake. At most 1 read and 1 write are outstanding.
- **Same-edge write and read.** A write commit and an AR handshake on the same edge → the read returns the pre-write value.
- **Back-to-back.** With `bready`/`rready` held high, the next transaction is accepted 2 cycles after the previous handshake (W_RESP→W_IDLE, R_DATA→R_IDLE).
- **Stability.** `bvalid`/`rvalid` never drop without the matching ready. Outputs change only on the clock edge.

## Configuration
- `AXIL_REG_WCOUNT_EN` defined:
  - WCOUNT is a DATA_WIDTH counter incremented on every commit with `bresp=0`. It wraps `2^DATA_WIDTH-1 → 0`.
  - Reading 0xC returns the count.
- `AXIL_REG_WCOUNT_EN` undefined:
  - No counter is built.
  - Reading 0xC returns 0 with `rresp=0`.
  - Writes to 0xC still return SLVERR.

## Test plan
- Reset, then release → `awready=wready=arready=1` on the first edge. A read of 0x0 returns `REG0_RESET` with `rresp=0`.
- Write 0x0=0x0000_00FF (all strobes), then 0x4=0xFFFF_FF02 → `bresp=0` both times. A read of 0x8 returns 0x0000_0001 (wrap). With the macro defined, 0xC returns 2.
- Write 0x0=0xAABB_CCDD with `wstrb=0b0101` over prior value 0x1122_3344 → a read returns 0x11BB_33DD.
- W presented 3 cycles before AW, and `bready` held low for 4 cycles → `bvalid` stays 1 throughout, and exactly one commit occurs.
- Write 0x8, and read 0x10 with `BASE_ADDR=0` → `bresp=2`, `rresp=2`, `rdata=0`, no register changes, and WCOUNT is unchanged.
- Assert reset while in W_RESP with `bready=0` → `bvalid=0` after the edge, and REG0 returns to `REG0_RESET`.
